bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin sharing of one downstream bus port
// among NUM_MASTERS requesters, one transaction at a time.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter bit WRITE_RESP  = 1'b1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int GRANT_W     =
    (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic clk,
  input  logic reset_n,

  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   in_maddr,
  input  logic [NUM_MASTERS-1:0][1:0]          in_mcmd,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   in_mdata,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0] in_mbyteen,
  input  logic [NUM_MASTERS-1:0]               in_mrespaccept,
  output logic [NUM_MASTERS-1:0]               in_scmdaccept,
  output logic [NUM_MASTERS-1:0][1:0]          in_sresp,
  output logic [NUM_MASTERS-1:0][DATA_W-1:0]   in_sdata,

  output logic [ADDR_W-1:0]   out_maddr,
  output logic [1:0]          out_mcmd,
  output logic [DATA_W-1:0]   out_mdata,
  output logic [DATA_W/8-1:0] out_mbyteen,
  output logic                out_mrespaccept,
  output logic                out_mreset_n,
  input  logic                out_scmdaccept,
  input  logic [1:0]          out_sresp,
  input  logic [DATA_W-1:0]   out_sdata,

  output logic [GRANT_W-1:0] grant,
  output logic               busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WR    = 2'd1;
  localparam logic [1:0] RESP_NULL = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_q, rr_d;
  logic [GRANT_W-1:0] win;
  logic [GRANT_W-1:0] next_ptr;

  logic [NUM_MASTERS-1:0] req;

  logic [ADDR_W-1:0] sel_maddr;
  logic [1:0]        sel_mcmd;
  logic [DATA_W-1:0] sel_mdata;
  logic [BE_W-1:0]   sel_mbyteen;
  logic              sel_mrespaccept;

  logic cmd_fwd;
  logic resp_fwd;

  // First requester at or after p, wrapping at NUM_MASTERS.
  function automatic logic [GRANT_W-1:0] rr_pick(
    input logic [NUM_MASTERS-1:0] r,
    input logic [GRANT_W-1:0]     p
  );
    logic [GRANT_W-1:0] w;
    logic               found;
    int                 idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(p) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = GRANT_W'(idx);
      end
    end
    return w;
  endfunction

  // Request vector and round-robin winner.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = (in_mcmd[i] != CMD_IDLE);
    end
    win = rr_pick(req, rr_q);
  end

  // Pointer to the requester after the current owner.
  always_comb begin
    next_ptr = '0;
    if (grant_q != GRANT_W'(NUM_MASTERS - 1)) begin
      next_ptr = grant_q + GRANT_W'(1);
    end
  end

  // Mux of the granted requester's command fields.
  always_comb begin
    sel_maddr       = '0;
    sel_mcmd        = CMD_IDLE;
    sel_mdata       = '0;
    sel_mbyteen     = '0;
    sel_mrespaccept = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_maddr       = in_maddr[i];
        sel_mcmd        = in_mcmd[i];
        sel_mdata       = in_mdata[i];
        sel_mbyteen     = in_mbyteen[i];
        sel_mrespaccept = in_mrespaccept[i];
      end
    end
  end

  // Sequencing: next state, grant, pointer and downstream drive.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    cmd_fwd         = 1'b0;
    resp_fwd        = 1'b0;
    out_maddr       = '0;
    out_mcmd        = CMD_IDLE;
    out_mdata       = '0;
    out_mbyteen     = '0;
    out_mrespaccept = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = win;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        out_maddr       = sel_maddr;
        out_mcmd        = sel_mcmd;
        out_mdata       = sel_mdata;
        out_mbyteen     = sel_mbyteen;
        out_mrespaccept = sel_mrespaccept;
        cmd_fwd         = 1'b1;
        if (sel_mcmd == CMD_IDLE) begin
          // requester gave up: keep its turn
          state_d = S_IDLE;
        end else if (out_scmdaccept) begin
          if (sel_mcmd == CMD_WR && !WRITE_RESP) begin
            state_d = S_IDLE;
            rr_d    = next_ptr;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        out_mrespaccept = sel_mrespaccept;
        resp_fwd        = 1'b1;
        if (out_sresp != RESP_NULL && sel_mrespaccept) begin
          state_d = S_IDLE;
          rr_d    = next_ptr;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Upstream return path: only the owner sees accept/response.
  always_comb begin
    in_scmdaccept = '0;
    in_sresp      = '0;
    in_sdata      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        in_scmdaccept[i] = cmd_fwd && out_scmdaccept;
        if (resp_fwd) begin
          in_sresp[i] = out_sresp;
          in_sdata[i] = out_sdata;
        end
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign out_mreset_n = reset_n;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven and hand-sequenced checks of the
// round-robin bus arbiter, with grant/response scoreboards.
module tb_bus_arbiter;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WR   = 2'd1;
  localparam logic [1:0] C_RD   = 2'd2;
  localparam logic [1:0] R_NULL = 2'd0;
  localparam logic [1:0] R_DVA  = 2'd1;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic clk;
  logic reset_n;

  logic [3:0][31:0] in_maddr;
  logic [3:0][1:0]  in_mcmd;
  logic [3:0][31:0] in_mdata;
  logic [3:0][3:0]  in_mbyteen;
  logic [3:0]       in_mrespaccept;
  logic [3:0]       in_scmdaccept;
  logic [3:0][1:0]  in_sresp;
  logic [3:0][31:0] in_sdata;
  logic [31:0] out_maddr;
  logic [1:0]  out_mcmd;
  logic [31:0] out_mdata;
  logic [3:0]  out_mbyteen;
  logic        out_mrespaccept;
  logic        out_mreset_n;
  logic        out_scmdaccept;
  logic [1:0]  out_sresp;
  logic [31:0] out_sdata;
  logic [1:0]  grant;
  logic        busy;

  logic [1:0][31:0] b_in_maddr;
  logic [1:0][1:0]  b_in_mcmd;
  logic [1:0][31:0] b_in_mdata;
  logic [1:0][3:0]  b_in_mbyteen;
  logic [1:0]       b_in_mrespaccept;
  logic [1:0]       b_in_scmdaccept;
  logic [1:0][1:0]  b_in_sresp;
  logic [1:0][31:0] b_in_sdata;
  logic [31:0] b_out_maddr;
  logic [1:0]  b_out_mcmd;
  logic [31:0] b_out_mdata;
  logic [3:0]  b_out_mbyteen;
  logic        b_out_mrespaccept;
  logic        b_out_mreset_n;
  logic        b_out_scmdaccept;
  logic [1:0]  b_out_sresp;
  logic [31:0] b_out_sdata;
  logic        b_grant;
  logic        b_busy;

  bus_arbiter #(
    .NUM_MASTERS(4), .WRITE_RESP(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_maddr(in_maddr), .in_mcmd(in_mcmd),
    .in_mdata(in_mdata), .in_mbyteen(in_mbyteen),
    .in_mrespaccept(in_mrespaccept),
    .in_scmdaccept(in_scmdaccept),
    .in_sresp(in_sresp), .in_sdata(in_sdata),
    .out_maddr(out_maddr), .out_mcmd(out_mcmd),
    .out_mdata(out_mdata), .out_mbyteen(out_mbyteen),
    .out_mrespaccept(out_mrespaccept),
    .out_mreset_n(out_mreset_n),
    .out_scmdaccept(out_scmdaccept),
    .out_sresp(out_sresp), .out_sdata(out_sdata),
    .grant(grant), .busy(busy)
  );

  bus_arbiter #(
    .NUM_MASTERS(2), .WRITE_RESP(1'b0)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_maddr(b_in_maddr), .in_mcmd(b_in_mcmd),
    .in_mdata(b_in_mdata), .in_mbyteen(b_in_mbyteen),
    .in_mrespaccept(b_in_mrespaccept),
    .in_scmdaccept(b_in_scmdaccept),
    .in_sresp(b_in_sresp), .in_sdata(b_in_sdata),
    .out_maddr(b_out_maddr), .out_mcmd(b_out_mcmd),
    .out_mdata(b_out_mdata), .out_mbyteen(b_out_mbyteen),
    .out_mrespaccept(b_out_mrespaccept),
    .out_mreset_n(b_out_mreset_n),
    .out_scmdaccept(b_out_scmdaccept),
    .out_sresp(b_out_sresp), .out_sdata(b_out_sdata),
    .grant(b_grant), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [1:0]  gq[$];
  logic [33:0] rq[$];

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  cmd;
    int          acc_dly;
    int          resp_dly;
    logic [1:0]  resp;
    logic [1:0]  expg;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic pop_grant(input logic [1:0] act);
    logic [1:0] e;
    if (gq.size() == 0) begin
      chk("sb_grant_empty", 64'd0, 64'd1);
    end else begin
      e = gq.pop_front();
      chk("grant", 64'(act), 64'(e));
    end
  endtask

  task automatic pop_resp(input logic [33:0] act);
    logic [33:0] e;
    if (rq.size() == 0) begin
      chk("sb_resp_empty", 64'd0, 64'd1);
    end else begin
      e = rq.pop_front();
      chk("resp_fwd", 64'(act), 64'(e));
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [3:0]  mask,
                         input logic [1:0]  cmd,
                         input int          acc_dly,
                         input int          resp_dly,
                         input logic [1:0]  resp,
                         input logic [1:0]  expg,
                         input logic [31:0] data);
    bit ok;
    logic [3:0][1:0] es;
    logic [3:0] ea;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      if (mask[m]) in_mcmd[m] = cmd;
    end
    gq.push_back(expg);
    wait_busy(ok);
    if (!ok) begin
      chk("busy_timeout", 64'd0, 64'd1);
      in_mcmd = '0;
      return;
    end
    pop_grant(grant);
    chk("cmd_mux", 64'(out_mcmd), 64'(cmd));
    chk("addr_mux", 64'(out_maddr),
        64'(32'h40 + 32'h100 * expg));
    chk("data_mux", 64'(out_mdata),
        64'(32'hA000_0000 + expg));
    for (int k = 0; k < acc_dly; k++) begin
      chk("early_acc", 64'(in_scmdaccept), 64'd0);
      @(negedge clk);
      chk("cmd_hold", 64'(busy), 64'd1);
    end
    out_scmdaccept = 1'b1;
    #1;
    ea = '0;
    ea[expg] = 1'b1;
    chk("acc_route", 64'(in_scmdaccept), 64'(ea));
    @(negedge clk);
    out_scmdaccept = 1'b0;
    in_mcmd = '0;
    chk("resp_state", 64'(busy), 64'd1);
    out_sresp = resp;
    out_sdata = data;
    in_mrespaccept[expg] = (resp_dly == 0);
    rq.push_back({resp, data});
    #1;
    pop_resp({in_sresp[expg], in_sdata[expg]});
    es = '0;
    es[expg] = resp;
    chk("resp_route", 64'(in_sresp), 64'(es));
    for (int k = 0; k < resp_dly; k++) begin
      chk("bp_macc", 64'(out_mrespaccept), 64'd0);
      @(negedge clk);
      chk("bp_hold", 64'(busy), 64'd1);
    end
    in_mrespaccept[expg] = 1'b1;
    #1;
    chk("macc_pass", 64'(out_mrespaccept), 64'd1);
    @(negedge clk);
    chk("txn_done", 64'(busy), 64'd0);
    out_sresp = R_NULL;
    out_sdata = '0;
    in_mrespaccept = '0;
    #1;
    chk("resp_clear", 64'(in_sresp), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit done;
    bit prev_b;
    int ngr;
    int idle_run;
    int acc_cnt[4];
    int resp_cnt[4];

    n_chk = 0;
    n_pass = 0;

    tbl[0] = '{4'b0010, C_RD, 2, 0, R_DVA, 2'd1, 32'hDEAD_BEEF};
    tbl[1] = '{4'b0001, C_WR, 0, 0, R_DVA, 2'd0, 32'h0000_0001};
    tbl[2] = '{4'b1111, C_RD, 1, 3, R_DVA, 2'd1, 32'h1234_5678};
    tbl[3] = '{4'b1001, C_WR, 0, 1, R_ERR, 2'd3, 32'h0000_0000};
    tbl[4] = '{4'b1100, C_RD, 0, 0, R_ERR, 2'd2, 32'hCAFE_0004};
    tbl[5] = '{4'b0111, C_RD, 1, 0, R_DVA, 2'd0, 32'hCAFE_0005};
    tbl[6] = '{4'b0100, C_WR, 0, 2, R_DVA, 2'd2, 32'h0000_0006};
    tbl[7] = '{4'b1000, C_RD, 0, 0, R_DVA, 2'd3, 32'hCAFE_0007};

    reset_n = 1'b0;
    in_mcmd = '0;
    in_mrespaccept = '0;
    out_scmdaccept = 1'b0;
    out_sresp = R_NULL;
    out_sdata = '0;
    for (int m = 0; m < 4; m++) begin
      in_maddr[m] = 32'h40 + 32'h100 * m;
      in_mdata[m] = 32'hA000_0000 + m;
      in_mbyteen[m] = 4'hF;
    end
    b_in_mcmd = '0;
    b_in_mrespaccept = '0;
    b_out_scmdaccept = 1'b0;
    b_out_sresp = R_NULL;
    b_out_sdata = '0;
    for (int m = 0; m < 2; m++) begin
      b_in_maddr[m] = 32'h80 + m;
      b_in_mdata[m] = 32'hB000_0000 + m;
      b_in_mbyteen[m] = 4'hF;
    end

    // reset holds idle even with a pending request
    in_mcmd[1] = C_RD;
    #22;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_mcmd", 64'(out_mcmd), 64'd0);
    chk("rst_macc", 64'(out_mrespaccept), 64'd0);
    chk("rst_sacc", 64'(in_scmdaccept), 64'd0);
    chk("rst_sresp", 64'(in_sresp), 64'd0);
    chk("rst_sdata", 64'(|in_sdata), 64'd0);
    chk("rst_mreset", 64'(out_mreset_n), 64'd0);
    chk("rst_busy2", 64'(b_busy), 64'd0);
    in_mcmd = '0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mreset_follow", 64'(out_mreset_n), 64'd1);

    // writes completing on accept
    @(negedge clk);
    b_in_mcmd[0] = C_WR;
    b_in_mcmd[1] = C_WR;
    b_out_scmdaccept = 1'b1;
    gq.push_back(2'd0);
    gq.push_back(2'd1);
    @(negedge clk);
    chk("nwr_busy0", 64'(b_busy), 64'd1);
    pop_grant({1'b0, b_grant});
    chk("nwr_acc0", 64'(b_in_scmdaccept), 64'd1);
    @(negedge clk);
    chk("nwr_no_resp", 64'(b_busy), 64'd0);
    @(negedge clk);
    chk("nwr_busy1", 64'(b_busy), 64'd1);
    pop_grant({1'b0, b_grant});
    chk("nwr_acc1", 64'(b_in_scmdaccept), 64'd2);
    @(negedge clk);
    chk("nwr_idle", 64'(b_busy), 64'd0);
    b_in_mcmd = '0;
    b_out_scmdaccept = 1'b0;

    // table of single transactions, rr pointer from 0
    for (int v = 0; v < 8; v++) begin
      run_txn(tbl[v].mask, tbl[v].cmd, tbl[v].acc_dly,
              tbl[v].resp_dly, tbl[v].resp, tbl[v].expg,
              tbl[v].data);
    end

    // four writers requesting continuously
    @(negedge clk);
    in_mcmd = {C_WR, C_WR, C_WR, C_WR};
    out_scmdaccept = 1'b1;
    out_sresp = R_DVA;
    out_sdata = 32'h5A5A_5A5A;
    in_mrespaccept = '1;
    gq.push_back(2'd0);
    gq.push_back(2'd1);
    gq.push_back(2'd2);
    gq.push_back(2'd3);
    gq.push_back(2'd0);
    prev_b = 1'b0;
    idle_run = 0;
    ngr = 0;
    done = 1'b0;
    for (int m = 0; m < 4; m++) begin
      acc_cnt[m] = 0;
      resp_cnt[m] = 0;
    end
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (in_scmdaccept[m]) acc_cnt[m]++;
        if (in_sresp[m] == R_DVA) resp_cnt[m]++;
      end
      if (busy && !prev_b) begin
        ngr++;
        pop_grant(grant);
        if (ngr > 1) chk("rr_gap", 64'(idle_run), 64'd1);
        idle_run = 0;
        if (ngr == 5) begin
          in_mcmd[1] = C_IDLE;
          in_mcmd[2] = C_IDLE;
          in_mcmd[3] = C_IDLE;
        end
      end else if (!busy) begin
        idle_run++;
        if (prev_b && ngr == 5) begin
          done = 1'b1;
          in_mcmd = '0;
        end
      end
      prev_b = busy;
    end
    chk("contention_done", 64'(done), 64'd1);
    for (int m = 0; m < 4; m++) begin
      chk("acc_count", 64'(acc_cnt[m]), (m == 0) ? 64'd2 : 64'd1);
      chk("dva_count", 64'(resp_cnt[m]), (m == 0) ? 64'd2 : 64'd1);
    end
    in_mcmd = '0;
    out_scmdaccept = 1'b0;
    out_sresp = R_NULL;
    out_sdata = '0;
    in_mrespaccept = '0;

    // abandoned command keeps the pointer
    @(negedge clk);
    in_mcmd[2] = C_RD;
    gq.push_back(2'd2);
    wait_busy(ok);
    if (!ok) chk("abandon_timeout", 64'd0, 64'd1);
    else pop_grant(grant);
    in_mcmd[2] = C_IDLE;
    out_sresp = R_DVA;
    out_sdata = 32'hBAD0_BAD0;
    #1;
    chk("abandon_mcmd", 64'(out_mcmd), 64'd0);
    chk("abandon_acc", 64'(in_scmdaccept), 64'd0);
    @(negedge clk);
    chk("abandon_idle", 64'(busy), 64'd0);
    chk("abandon_noresp", 64'(in_sresp), 64'd0);
    out_sresp = R_NULL;
    out_sdata = '0;
    run_txn(4'b1100, C_RD, 0, 0, R_DVA, 2'd2, 32'h0000_C0DE);

    // asynchronous reset while a response is pending
    @(negedge clk);
    in_mcmd[3] = C_RD;
    gq.push_back(2'd3);
    wait_busy(ok);
    if (!ok) chk("rstmid_timeout", 64'd0, 64'd1);
    else pop_grant(grant);
    out_scmdaccept = 1'b1;
    @(negedge clk);
    out_scmdaccept = 1'b0;
    in_mcmd = '0;
    out_sresp = R_DVA;
    out_sdata = 32'h0000_1234;
    in_mrespaccept = '0;
    #1;
    chk("rstmid_fwd", 64'(in_sresp[3]), 64'(R_DVA));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_sresp", 64'(in_sresp), 64'd0);
    chk("rstmid_sdata", 64'(|in_sdata), 64'd0);
    chk("rstmid_grant", 64'(grant), 64'd0);
    chk("rstmid_mreset", 64'(out_mreset_n), 64'd0);
    out_sresp = R_NULL;
    out_sdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(4'b0001, C_RD, 0, 0, R_DVA, 2'd0, 32'h600D_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
